// File: rtl/privilege_trap_controller.sv
// privilege_trap_controller: sequences user->kernel traps and kernel->user returns, owns the Mode bit
module privilege_trap_controller #(
   parameter int              PC_W         = 16,
   parameter logic [PC_W-1:0] VEC_ADDR     = 'h0010,
   parameter int              FLUSH_CYCLES = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_illegal_pc,
   input  logic            i_illegal_mem,
   input  logic [PC_W-1:0] i_pc_fault,
   input  logic [PC_W-1:0] i_pc_mem,
   input  logic            i_syscall,
   input  logic [PC_W-1:0] i_pc_sys,
   input  logic            i_rti,
   input  logic            i_stall,
   output logic            o_mode,
   output logic            o_flush,
   output logic            o_redirect,
   output logic [PC_W-1:0] o_redirect_pc,
   output logic [PC_W-1:0] o_epc,
   output logic [1:0]      o_cause,
   output logic            o_busy
);
   localparam int CW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
   typedef enum logic [2:0] {S_KERNEL, S_USER, S_DRAIN, S_VECTOR, S_RETURN} state_t;
   state_t          r_state, w_state;
   logic [CW-1:0]   r_cnt, w_cnt;
   logic [PC_W-1:0] w_epc, w_rpc;
   logic [1:0]      w_cause;
   logic            w_event;
   assign w_event = i_illegal_mem | i_illegal_pc | i_syscall;
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_epc   = o_epc;
      w_cause = o_cause;
      w_rpc   = o_redirect_pc;
      case (r_state)
         S_USER: if (w_event) begin
            w_state = S_DRAIN;
            w_cnt   = CW'(FLUSH_CYCLES - 1);
            // older instruction (memory stage) wins over the branch, which wins over the syscall
            w_epc   = i_illegal_mem ? i_pc_mem : i_illegal_pc ? i_pc_fault : i_pc_sys + 1'b1;
            w_cause = i_illegal_mem ? 2'b10 : i_illegal_pc ? 2'b01 : 2'b11;
         end
         S_DRAIN: if (r_cnt == '0) begin
            w_state = S_VECTOR;
            w_rpc   = VEC_ADDR;
         end else w_cnt = r_cnt - 1'b1;
         S_VECTOR: w_state = i_stall ? S_VECTOR : S_KERNEL;
         S_KERNEL: if (i_rti) begin
            w_state = S_RETURN;
            w_rpc   = o_epc;
         end
         S_RETURN: if (!i_stall) begin
            w_state = S_USER;
            w_cause = 2'b00;
         end
         default: w_state = S_KERNEL;
      endcase
   end
   // outputs are registered from the next state so they line up with r_state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_KERNEL;
         r_cnt         <= '0;
         o_mode        <= 1'b1;
         o_flush       <= 1'b0;
         o_redirect    <= 1'b0;
         o_redirect_pc <= '0;
         o_epc         <= '0;
         o_cause       <= 2'b00;
         o_busy        <= 1'b0;
      end else begin
         r_state       <= w_state;
         r_cnt         <= w_cnt;
         o_mode        <= w_state != S_USER;
         o_flush       <= w_state == S_DRAIN;
         o_redirect    <= w_state == S_VECTOR || w_state == S_RETURN;
         o_redirect_pc <= w_rpc;
         o_epc         <= w_epc;
         o_cause       <= w_cause;
         o_busy        <= w_state == S_DRAIN || w_state == S_VECTOR || w_state == S_RETURN;
      end
   end
endmodule
